mux_rr_arbiter8: RTL and testbench
==================================

# mux_rr_arbiter8

Round-robin arbiter and sequencer for the 8:1 one-bit select mux lane. Eight requesters compete for the mux; the block generates the registered 3-bit select and one-hot grant, holds a grant for a bounded burst, and presents the selected bit to one downstream consumer with a valid/ready handshake. It sits between the requester bank and the shared mux output path.

## Interface
- `MAX_HOLD`, default 4: maximum accepted beats per grant while other lanes are pending; legal range 1..16.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  8  per-lane request; bit i is lane i.
- `in`  input  8  per-lane data bit; bit i is valid while `req[i]`=1.
- `out_rdy`  input  1  downstream ready.
- `sel`  output  3  registered mux select, the binary index of the granted lane.
- `gnt`  output  8  registered one-hot grant; all zero when idle.
- `gnt_vld`  output  1  registered; high while a grant is active.
- `out`  output  1  combinational `in[sel]` when `gnt_vld`=1, else 0.

## Operation
- States are IDLE and GRANT. Internal registers are the state, a 3-bit `last` pointer and a 4-bit `hold_cnt`.
- Pick function: the first lane i with `req[i]`=1, searching `last+1`, `last+2`, … with wrap-around from 7 to 0.
- IDLE:
  - If any `req` bit is set, go to GRANT with the picked lane.
  - On entering GRANT: load `sel`, `gnt` and `last` with the picked lane, set `gnt_vld`=1, clear `hold_cnt`.
- GRANT, evaluated in this order:
  1. If `req[sel]`=0, the requester withdrew. Release the lane, regardless of `out_rdy`. If another lane requests, grant the picked lane in the same edge (no idle gap); otherwise go to IDLE with `gnt`=0, `gnt_vld`=0 and `sel` held.
  2. A beat is accepted when `gnt_vld`=1 and `out_rdy`=1. On each accepted beat, `hold_cnt` increments.
  3. If an accepted beat makes `hold_cnt` reach `MAX_HOLD` and another lane requests, rotate to the picked lane and clear `hold_cnt`.
  4. If an accepted beat makes `hold_cnt` reach `MAX_HOLD` and only the current lane requests, keep the grant and clear `hold_cnt`.
  5. If `out_rdy`=0 (stall), `sel`, `gnt` and `hold_cnt` are all frozen.
- `last` always equals the most recently granted lane, so lane `last` has the lowest priority at the next pick.
- Reset values:
  - Outputs: `gnt`=0, `gnt_vld`=0, `sel`=0, `out`=0.
  - Internal: state IDLE, `hold_cnt`=0, `last`=7, so lane 0 wins first.
- Reset asserted mid-burst: at the next edge, all registers return to their reset values. The in-flight beat is dropped and no grant survives.
- `req`=8'hFF steady with `out_rdy`=1: lanes are served in the order 0,1,…,7,0, each for `MAX_HOLD` beats.

## Timing
- Grant latency: `req` sampled at edge t, so `gnt`, `sel` and `gnt_vld` are valid after edge t. Minimum latency is one cycle from request assertion.
- Switching between lanes costs zero bubble cycles.
- `out` has no register stage; it is valid in the same cycle as `gnt_vld`.
- A beat is accepted on the edge where `gnt_vld`=1 and `out_rdy`=1. The requester may change `in` or `req` after that edge.
- Worst-case wait for a lane with continuous `req` and `out_rdy`=1: 7×`MAX_HOLD` accepted beats.

## Configuration
- `MUX_ARB_HOLD_EN` defined: burst hold is enabled, with the `hold_cnt` logic as described above.
- `MUX_ARB_HOLD_EN` undefined:
  - `hold_cnt` is not built and `MAX_HOLD` is ignored.
  - The arbiter behaves as if `MAX_HOLD`=1: it rotates after every accepted beat whenever another lane is pending.
  - All other behaviour is identical.

## Structure
- Package `mux_arb_pkg` holds:
  - the state enum `arb_state_t` {IDLE, GRANT};
  - `N_LANES`=8 and `SEL_W`=3;
  - the one-hot-to-index conversion function.
- Sub-module `rr_pick8`: combinational picker. Inputs are `req[7:0]`, `last[2:0]` and `excl_en` (excludes the current lane when rotating). Outputs are `pick_idx[2:0]` and `pick_vld`.

## Test plan
- Reset, then `req`=8'h00 for 5 cycles -> `gnt`=0, `gnt_vld`=0, `sel`=0, `out`=0.
- Reset, `req`=8'h24, `out_rdy`=1, `MAX_HOLD`=4 -> lane 2 is granted for 4 beats, then lane 5 for 4 beats, then lane 2 again.
- Lane 3 only, `in[3]` toggling, `out_rdy`=1 for 10 cycles -> `sel`=3 held throughout and `out` follows `in[3]`.
- Lane 1 granted with `req`=8'h03 and `out_rdy`=0 for 6 cycles -> `gnt` stays 8'h02 and `hold_cnt` stays frozen; after `out_rdy` rises, lane 1 completes its remaining beats, then lane 0 is granted with no bubble.
- Lane 6 deasserts `req` mid-burst while `out_rdy`=0 and `req[0]`=1 -> the next edge gives `gnt`=8'h01 and `sel`=0.
- `rst` asserted while lane 4 is granted -> the next edge gives `gnt`=0 and `gnt_vld`=0; with `req`=8'hFF, the first grant after reset is lane 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types, sizes and helpers for the 8-lane round-robin mux arbiter
package mux_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int N_LANES = 8;
    localparam int SEL_W   = 3;

    function automatic logic [SEL_W-1:0] oh2idx(input logic [N_LANES-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_LANES; i++)
            if (oh[i]) idx = idx | SEL_W'(i);
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: combinational round-robin picker, searches last+1 .. last with wrap
module rr_pick8
    import mux_arb_pkg::*;
(
    input  logic [N_LANES-1:0] req,
    input  logic [SEL_W-1:0]   last,
    input  logic               excl_en,
    output logic [SEL_W-1:0]   pick_idx,
    output logic               pick_vld
);

    logic [N_LANES-1:0] rot;
    logic [N_LANES-1:0] first;

    // rot[k] is lane last+1+k, so the top bit is lane last itself
    always_comb begin
        rot = '0;
        for (int i = 0; i < N_LANES; i++)
            rot[i] = req[SEL_W'(int'(last) + 1 + i)];
        rot[N_LANES-1] = rot[N_LANES-1] & ~excl_en;
    end

    assign first    = rot & -rot;
    assign pick_idx = last + SEL_W'(1) + oh2idx(first);
    assign pick_vld = |rot;

endmodule

// File: rtl/mux_rr_arbiter8.sv
// mux_rr_arbiter8: round-robin arbiter and sequencer for the 8:1 one-bit mux lane.
// Define MUX_ARB_HOLD_EN to enable MAX_HOLD-beat bursts; otherwise it rotates every beat.
module mux_rr_arbiter8
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LANES-1:0] req,
    input  logic [N_LANES-1:0] in,
    input  logic               out_rdy,
    output logic [SEL_W-1:0]   sel,
    output logic [N_LANES-1:0] gnt,
    output logic               gnt_vld,
    output logic               out
);

    if (MAX_HOLD < 1 || MAX_HOLD > 16) begin : g_bad_hold
        $error("MAX_HOLD must be in 1..16");
    end

    arb_state_t       state;
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_vld;
    logic             hold_done;
    logic             repick;

    rr_pick8 u_pick (
        .req      (req),
        .last     (last),
        .excl_en  (state == GRANT),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

`ifdef MUX_ARB_HOLD_EN
    logic [3:0] hold_cnt;
    assign hold_done = hold_cnt == 4'(MAX_HOLD - 1);
    always_ff @(posedge clk) begin
        if (rst || repick)
            hold_cnt <= '0;
        else if (state == GRANT && out_rdy)
            hold_cnt <= hold_cnt + 4'd1;
    end
`else
    assign hold_done = 1'b1;
`endif

    // withdrawal or an exhausted burst reopens arbitration; stalls keep everything frozen
    assign repick = state == IDLE || !req[sel] || (out_rdy && hold_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= '0;
            gnt     <= '0;
            gnt_vld <= 1'b0;
            last    <= '1;
        end else if (repick && pick_vld) begin
            state   <= GRANT;
            sel     <= pick_idx;
            gnt     <= N_LANES'(1) << pick_idx;
            gnt_vld <= 1'b1;
            last    <= pick_idx;
        end else if (state == GRANT && !req[sel]) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_vld <= 1'b0;
        end
    end

    assign out = gnt_vld & in[sel];

endmodule

// File: tb/tb_mux_rr_arbiter8.sv
// tb_mux_rr_arbiter8: directed self-checking bench for mux_rr_arbiter8
module tb_mux_rr_arbiter8;

`ifdef MUX_ARB_HOLD_EN
    localparam int HB = 4;
`else
    localparam int HB = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic [7:0] in = '0;
    logic       out_rdy = 1'b0;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       gnt_vld;
    logic       out;

    int n_tests = 0;
    int n_fail = 0;

    mux_rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .in      (in),
        .out_rdy (out_rdy),
        .sel     (sel),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .out     (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic exp_lane(input string tag, input int lane);
        chk({tag, ".gnt"}, gnt, 8'(1) << lane);
        chk({tag, ".sel"}, 8'(sel), 8'(lane));
        chk({tag, ".vld"}, 8'(gnt_vld), 8'd1);
    endtask

    initial begin
        // idle after reset
        do_reset();
        req = 8'h00; in = 8'hFF; out_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("idle.gnt", gnt, 8'h00);
            chk("idle.vld", 8'(gnt_vld), 8'd0);
            chk("idle.sel", 8'(sel), 8'd0);
            chk("idle.out", 8'(out), 8'd0);
        end

        // two lanes alternate in bursts
        do_reset();
        req = 8'h24; in = 8'h20; out_rdy = 1'b1;
        for (int k = 0; k <= 2 * HB; k++) begin
            step();
            exp_lane("burst", ((k / HB) % 2) ? 5 : 2);
            chk("burst.out", 8'(out), ((k / HB) % 2) ? 8'd1 : 8'd0);
        end

        // single lane keeps grant, out follows data
        do_reset();
        req = 8'h08; out_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in = k[0] ? 8'h08 : 8'hF7;
            step();
            exp_lane("solo", 3);
            chk("solo.out", 8'(out), 8'(k[0]));
        end
        req = 8'h00; in = 8'hFF;
        step();
        chk("drop.gnt", gnt, 8'h00);
        chk("drop.vld", 8'(gnt_vld), 8'd0);
        chk("drop.sel", 8'(sel), 8'd3);
        chk("drop.out", 8'(out), 8'd0);

        // all lanes: 0..7 then 0
        do_reset();
        req = 8'hFF; out_rdy = 1'b1;
        for (int k = 0; k <= 8 * HB; k++) begin
            step();
            exp_lane("ring", (k / HB) % 8);
        end

        // stall freezes grant and hold count
        do_reset();
        req = 8'h02; out_rdy = 1'b0;
        step();
        exp_lane("stall0", 1);
        req = 8'h03;
        for (int k = 0; k < 6; k++) begin
            step();
            exp_lane("stall", 1);
        end
        out_rdy = 1'b1;
        for (int k = 1; k <= HB; k++) begin
            step();
            exp_lane("resume", (k < HB) ? 1 : 0);
        end

        // withdrawal during stall hands over immediately
        do_reset();
        req = 8'h40; out_rdy = 1'b1;
        step();
        exp_lane("wd0", 6);
        req = 8'h41; out_rdy = 1'b0;
        step();
        exp_lane("wd1", 6);
        req = 8'h01;
        step();
        exp_lane("wd2", 0);

        // reset mid-burst
        do_reset();
        req = 8'h10; out_rdy = 1'b1;
        step();
        exp_lane("rst0", 4);
        rst = 1'b1; req = 8'hFF;
        step();
        chk("rst.gnt", gnt, 8'h00);
        chk("rst.vld", 8'(gnt_vld), 8'd0);
        chk("rst.sel", 8'(sel), 8'd0);
        rst = 1'b0;
        step();
        exp_lane("rst1", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
